// File: rtl/test_pattern_gen.sv
// test_pattern_gen: burst test-pattern source on a valid/ready stream.
// A start pulse in IDLE launches a burst of len_i beats.
// Patterns: incrementing, Galois LFSR, walking-one, checkerboard.
// Optional build macro TPG_ERR_INJECT_EN adds err_inj_i, which flips
// bit 0 of the next transferred beat on the output only.
//
// state  | meaning
// IDLE   | waiting for start_i
// RUN    | presenting beats, valid_o/busy_o high
// DONE   | one-cycle done_o pulse, then back to IDLE
module test_pattern_gen #(
    parameter int                DATA_W    = 5,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_POLY = DATA_W'(5'h14)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] seed_i,
    input  logic [CNT_W-1:0]  len_i,
`ifdef TPG_ERR_INJECT_EN
    input  logic              err_inj_i,
`endif
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [1:0] M_INCR  = 2'd0;
    localparam logic [1:0] M_LFSR  = 2'd1;
    localparam logic [1:0] M_WALK1 = 2'd2;

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_data;
    logic              w_xfer;
    logic              w_last;

    function automatic logic [DATA_W-1:0] f_first(input logic [1:0] mode,
                                                  input logic [DATA_W-1:0] seed);
        case (mode)
            M_LFSR:  return (seed == '0) ? ONE : seed;
            M_WALK1: return ONE;
            default: return seed;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] f_next(input logic [1:0] mode,
                                                 input logic [DATA_W-1:0] d);
        case (mode)
            M_INCR:  return d + ONE;
            M_LFSR:  return d[0] ? ((d >> 1) ^ LFSR_POLY) : (d >> 1);
            M_WALK1: return {d[DATA_W-2:0], d[DATA_W-1]};
            default: return ~d;
        endcase
    endfunction

    assign w_xfer = (r_state == S_RUN) && ready_i;
    // r_cnt never exceeds len-1 in RUN, so a full-range len cannot overflow it
    assign w_last = (r_cnt == r_len - 1'b1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (len_i != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_xfer && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Burst parameters, beat counter and pattern register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
        end else if (r_state == S_IDLE) begin
            if (start_i) begin
                r_mode <= mode_i;
                r_len  <= len_i;
                r_cnt  <= '0;
                if (len_i != '0) begin
                    r_data <= f_first(mode_i, seed_i);
                end
            end
        end else if (w_xfer) begin
            r_data <= f_next(r_mode, r_data);
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign valid_o = (r_state == S_RUN);
    assign busy_o  = (r_state == S_RUN);
    assign done_o  = (r_state == S_DONE);

`ifdef TPG_ERR_INJECT_EN
    logic r_err_arm;

    // Sticky error-inject request, consumed by the next transferred beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_arm <= 1'b0;
        end else if (r_state == S_DONE) begin
            r_err_arm <= 1'b0;
        end else if (w_xfer && r_err_arm) begin
            r_err_arm <= 1'b0;
        end else if (err_inj_i) begin
            r_err_arm <= 1'b1;
        end
    end

    assign data_o = r_data ^ {{(DATA_W-1){1'b0}}, r_err_arm & valid_o};
`else
    assign data_o = r_data;
`endif

endmodule
